// File: rtl/sdram_cache_fill.sv
// Line-fill engine: requests one SDRAM read burst and writes each 16-bit beat
// into the proper half of a 32-bit cache RAM word, critical word first.
// Handshakes: sd_req is held until a one-cycle sd_ack; every cycle in BURST
// with sd_valid high delivers exactly one beat (no back-pressure), and a beat
// coinciding with sd_ack is dropped because the ack is taken instead.
module sdram_cache_fill #(
  parameter int LINE_BEATS = 8,
  parameter int ADDR_W     = 10
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              fill_req,
  input  logic [ADDR_W-1:0] fill_addr,
  input  logic              fill_hw,
  output logic              fill_busy,
  output logic              crit_valid,
  output logic              fill_done,
  output logic              sd_req,
  input  logic              sd_ack,
  input  logic [15:0]       sd_data,
  input  logic              sd_valid,
  output logic              ram_wren,
  output logic [3:0]        ram_byteena,
  output logic [ADDR_W-1:0] ram_address,
  output logic [31:0]       ram_data,
  output logic [1:0]        fsm_state
);

  localparam int IDX_W = $clog2(LINE_BEATS);
  localparam int LW_W  = IDX_W - 1;
  localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(LINE_BEATS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    BURST = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] line_base;
  logic [IDX_W-1:0]  start_beat;
  logic [IDX_W-1:0]  beat_count;
  logic [IDX_W-1:0]  beat_idx;

  // Beat index wraps naturally at IDX_W bits, keeping the address inside the line.
  assign beat_idx  = start_beat + beat_count;
  assign fsm_state = state;

  // Fill sequencer with registered RAM write port and status outputs.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= IDLE;
      line_base   <= '0;
      start_beat  <= '0;
      beat_count  <= '0;
      fill_busy   <= 1'b0;
      crit_valid  <= 1'b0;
      fill_done   <= 1'b0;
      sd_req      <= 1'b0;
      ram_wren    <= 1'b0;
      ram_byteena <= 4'b0000;
      ram_address <= '0;
      ram_data    <= '0;
    end else begin
      ram_wren    <= 1'b0;
      ram_byteena <= 4'b0000;
      crit_valid  <= 1'b0;
      fill_done   <= 1'b0;
      case (state)
        IDLE: begin
          if (fill_req) begin
            line_base  <= {fill_addr[ADDR_W-1:LW_W], {LW_W{1'b0}}};
            start_beat <= {fill_addr[LW_W-1:0], fill_hw};
            fill_busy  <= 1'b1;
            sd_req     <= 1'b1;
            state      <= REQ;
          end
        end
        REQ: begin
          if (sd_ack) begin
            sd_req     <= 1'b0;
            beat_count <= '0;
            state      <= BURST;
          end
        end
        BURST: begin
          if (sd_valid) begin
            ram_wren    <= 1'b1;
            ram_address <= line_base | {{(ADDR_W-LW_W){1'b0}}, beat_idx[IDX_W-1:1]};
            ram_data    <= {sd_data, sd_data};
            // Big-endian: even beats land in the upper halfword.
            ram_byteena <= beat_idx[0] ? 4'b0011 : 4'b1100;
            crit_valid  <= (beat_count == '0);
            beat_count  <= beat_count + IDX_W'(1);
            if (beat_count == LAST_BEAT) begin
              fill_done <= 1'b1;
              state     <= DONE;
            end
          end
        end
        DONE: begin
          fill_busy <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_cache_fill.sv
// Self-checking bench for sdram_cache_fill: randomized fills compared against a
// line-arithmetic reference model through an expected-write queue.
module tb_sdram_cache_fill;

  localparam int LB = 8;
  localparam int AW = 10;
  localparam int W  = AW + 4 + 32 + 2;

  // Clock and reset
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset_n;
  logic          fill_req;
  logic [AW-1:0] fill_addr;
  logic          fill_hw;
  logic          fill_busy;
  logic          crit_valid;
  logic          fill_done;
  logic          sd_req;
  logic          sd_ack;
  logic [15:0]   sd_data;
  logic          sd_valid;
  logic          ram_wren;
  logic [3:0]    ram_byteena;
  logic [AW-1:0] ram_address;
  logic [31:0]   ram_data;
  logic [1:0]    fsm_state;

  sdram_cache_fill #(.LINE_BEATS(LB), .ADDR_W(AW)) dut (
    .clock(clock), .reset_n(reset_n), .fill_req(fill_req), .fill_addr(fill_addr),
    .fill_hw(fill_hw), .fill_busy(fill_busy), .crit_valid(crit_valid),
    .fill_done(fill_done), .sd_req(sd_req), .sd_ack(sd_ack), .sd_data(sd_data),
    .sd_valid(sd_valid), .ram_wren(ram_wren), .ram_byteena(ram_byteena),
    .ram_address(ram_address), .ram_data(ram_data), .fsm_state(fsm_state)
  );

  int tests_run = 0;
  int failed    = 0;
  bit mon_en    = 1'b0;

  logic [W-1:0]  exp_q[$];
  logic [AW-1:0] cur_addr;
  logic          cur_hw;
  logic [AW-1:0] last_addr;
  int            gap_tab[LB] = '{0, 2, 0, 1, 2, 0, 1, 0};

  // Reference model: the k-th received beat of a fill, from line arithmetic.
  function automatic logic [W-1:0] model_write(input int k, input logic [15:0] d);
    int words = LB / 2;
    int start = (int'(cur_addr) % words) * 2 + int'(cur_hw);
    int idx   = (start + k) % LB;
    int base  = int'(cur_addr) - (int'(cur_addr) % words);
    logic [AW-1:0] a  = AW'(base + idx / 2);
    logic [3:0]    be = (idx % 2 == 1) ? 4'b0011 : 4'b1100;
    return {a, be, d, d, (k == 0), (k == LB - 1)};
  endfunction

  // Scoreboard: every RAM write must match the head of the expected queue.
  always @(negedge clock) begin
    if (mon_en) begin
      if (ram_wren) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          failed++;
          $display("FAIL unexpected_write: got addr=%h be=%b data=%h, expected no write",
                   ram_address, ram_byteena, ram_data);
        end else begin
          logic [W-1:0] e;
          logic [W-1:0] g;
          e = exp_q.pop_front();
          g = {ram_address, ram_byteena, ram_data, crit_valid, fill_done};
          if (g !== e) begin
            failed++;
            $display("FAIL ram_write: got addr=%h be=%b data=%h crit=%b done=%b, expected addr=%h be=%b data=%h crit=%b done=%b",
                     g[W-1 -: AW], g[37:34], g[33:2], g[1], g[0],
                     e[W-1 -: AW], e[37:34], e[33:2], e[1], e[0]);
          end
        end
      end else begin
        tests_run++;
        if ({crit_valid, fill_done, ram_byteena} !== 6'b0) begin
          failed++;
          $display("FAIL idle_strobes: got crit=%b done=%b be=%b with no write, expected 0/0/0000",
                   crit_valid, fill_done, ram_byteena);
        end
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start_fill(input logic [AW-1:0] a, input logic hw);
    fill_addr = a;
    fill_hw   = hw;
    cur_addr  = a;
    cur_hw    = hw;
    fill_req  = 1'b1;
    tick();
    fill_req  = 1'b0;
    tests_run++;
    if (fill_busy !== 1'b1 || sd_req !== 1'b1) begin
      failed++;
      $display("FAIL start_fill: got busy=%b sd_req=%b, expected 1/1", fill_busy, sd_req);
    end
  endtask

  task automatic do_ack(input int delay, input bit valid_early, input bit valid_with_ack);
    for (int i = 0; i < delay; i++) begin
      sd_valid = valid_early;
      sd_data  = 16'($urandom);
      tests_run++;
      if (sd_req !== 1'b1) begin
        failed++;
        $display("FAIL sd_req_hold: got %b in wait cycle %0d, expected 1", sd_req, i);
      end
      tick();
    end
    sd_valid = valid_with_ack;
    sd_data  = 16'($urandom);
    sd_ack   = 1'b1;
    tick();
    sd_ack   = 1'b0;
    sd_valid = 1'b0;
    tests_run++;
    if (sd_req !== 1'b0) begin
      failed++;
      $display("FAIL sd_req_drop: got %b after ack, expected 0", sd_req);
    end
  endtask

  // gap_mode: 0 back-to-back, 1 random gaps, 2 fixed gap table
  task automatic do_burst(input int gap_mode, input bit fixed_data, input bit req_during);
    for (int k = 0; k < LB; k++) begin
      int gaps;
      logic [15:0] d;
      logic [W-1:0] e;
      gaps = (gap_mode == 0) ? 0 : (gap_mode == 1) ? int'($urandom_range(0, 2)) : gap_tab[k];
      for (int g = 0; g < gaps; g++) begin
        sd_valid = 1'b0;
        fill_req = req_during;
        fill_addr = AW'($urandom);
        tick();
      end
      fill_req = 1'b0;
      d = fixed_data ? 16'((k + 1) * 16'h1111) : 16'($urandom);
      e = model_write(k, d);
      last_addr = e[W-1 -: AW];
      exp_q.push_back(e);
      sd_valid = 1'b1;
      sd_data  = d;
      tick();
      sd_valid = 1'b0;
    end
    for (int t = 0; t < 10 && fill_busy !== 1'b0; t++) tick();
    tests_run++;
    if (fill_busy !== 1'b0) begin
      failed++;
      $display("FAIL busy_timeout: got busy=%b 10 cycles after last beat, expected 0", fill_busy);
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      failed++;
      $display("FAIL missing_writes: got %0d writes outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_all_zero(input string tag);
    tests_run++;
    if ({sd_req, fill_busy, crit_valid, fill_done, ram_wren, ram_byteena, ram_address, ram_data} !== '0) begin
      failed++;
      $display("FAIL %s: got req=%b busy=%b crit=%b done=%b wren=%b be=%b addr=%h data=%h, expected all 0",
               tag, sd_req, fill_busy, crit_valid, fill_done, ram_wren, ram_byteena, ram_address, ram_data);
    end
  endtask

  // Scenario tasks
  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    tick();
    check_all_zero("reset_initial");
    reset_n = 1'b1;
    tick();
    mon_en = 1'b1;
    // Abandon a fill part-way through the burst.
    start_fill(10'h155, 1'b0);
    do_ack(1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      logic [15:0] d;
      d = 16'($urandom);
      exp_q.push_back(model_write(k, d));
      sd_valid = 1'b1;
      sd_data  = d;
      tick();
    end
    sd_valid = 1'b1;
    reset_n  = 1'b0;
    tick();
    tick();
    check_all_zero("reset_mid_burst");
    reset_n = 1'b1;
    tick();
    sd_valid = 1'b0;
    tick();
    tests_run++;
    if (sd_req !== 1'b0 || fill_busy !== 1'b0 || exp_q.size() != 0) begin
      failed++;
      $display("FAIL reset_recover: got req=%b busy=%b outstanding=%0d, expected 0/0/0",
               sd_req, fill_busy, exp_q.size());
      exp_q.delete();
    end
    start_fill(10'h2C7, 1'b1);
    do_ack(0, 1'b0, 1'b0);
    do_burst(0, 1'b0, 1'b0);
  endtask

  task automatic test_stray_inputs();
    sd_ack   = 1'b1;
    sd_valid = 1'b1;
    tick();
    sd_ack   = 1'b0;
    sd_valid = 1'b0;
    tick();
    tests_run++;
    if (sd_req !== 1'b0 || fill_busy !== 1'b0) begin
      failed++;
      $display("FAIL stray_ack_idle: got req=%b busy=%b, expected 0/0", sd_req, fill_busy);
    end
  endtask

  task automatic test_aligned();
    start_fill(10'h040, 1'b0);
    do_ack(0, 1'b0, 1'b0);
    do_burst(0, 1'b1, 1'b0);
  endtask

  task automatic test_wrap();
    start_fill(10'h3FE, 1'b1);
    do_ack(2, 1'b0, 1'b0);
    do_burst(0, 1'b1, 1'b0);
  endtask

  task automatic test_gapped();
    start_fill(10'h123, 1'b0);
    do_ack(1, 1'b0, 1'b0);
    do_burst(2, 1'b0, 1'b0);
  endtask

  task automatic test_handshake();
    start_fill(10'h2A5, 1'b1);
    do_ack(5, 1'b1, 1'b1);
    do_burst(2, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (sd_req !== 1'b0 || fill_busy !== 1'b0) begin
        failed++;
        $display("FAIL req_ignored_busy: got req=%b busy=%b after done, expected 0/0", sd_req, fill_busy);
      end
      tick();
    end
    tests_run++;
    if (ram_byteena !== 4'b0000 || ram_address !== last_addr) begin
      failed++;
      $display("FAIL idle_hold: got be=%b addr=%h, expected 0000/%h", ram_byteena, ram_address, last_addr);
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 8; n++) begin
      start_fill(AW'($urandom), 1'($urandom));
      do_ack(int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
      do_burst(int'($urandom_range(0, 1)), 1'b0, 1'($urandom));
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    fill_req  = 1'b0;
    fill_addr = '0;
    fill_hw   = 1'b0;
    sd_ack    = 1'b0;
    sd_data   = '0;
    sd_valid  = 1'b0;
    test_reset();
    test_stray_inputs();
    test_aligned();
    test_wrap();
    test_gapped();
    test_handshake();
    test_back_to_back();
    tick();
    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
